pipelined_add_sub: RTL

- Parametrised, pipelined ripple-carry adder/subtractor, the successor to the single-bit full adder.
- Splits a WIDTH-bit add or subtract into STAGES equal slices, one slice per pipeline stage; the carry is registered between stages.
- Valid/ready stream interface with whole-pipeline stall, for use as a reusable datapath block that sustains one operation per clock.

---
 rtl/pipelined_add_sub_if.sv | 29 ++
 rtl/pipelined_add_sub.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub_if.sv
// Stream interface for pipelined_add_sub.
//   in_valid/in_ready : operation handshake, payload a, b, sub
//   out_valid/out_ready : result handshake, payload sum, cout, ovf
// master : drives operations and consumes results (the environment)
// slave  : accepts operations and produces results (the adder block)
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add (sub=0) or subtract (sub=1) is split into STAGES slices of
// WIDTH/STAGES bits; each pipeline stage computes one slice and registers the
// carry for the next. Whole-pipeline stall on out_valid & ~out_ready.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, flushes all in-flight operations
//   io    : slave side of pipelined_add_sub_if
//           in_valid/in_ready/a/b/sub  -> operation in
//           out_valid/out_ready/sum/cout/ovf -> result out
//           cout = carry out (add) or NOT borrow (sub); ovf = signed overflow
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_add_sub_if.slave    io
);

  // Reject illegal geometries at elaboration.
  if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_param_check
    $fatal(1, "pipelined_add_sub: illegal WIDTH/STAGES combination");
  end

  localparam int unsigned SW  = WIDTH / STAGES;
  localparam int unsigned SWP = SW + 1;

  // Every stage advances together; a full, stalled output freezes everything.
  logic adv_c;
  assign adv_c       = io.out_ready | ~io.out_valid;
  assign io.in_ready = adv_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * SW;       // result bits already produced
    localparam int unsigned HI  = LO + SW;      // result bits after this stage
    localparam int unsigned RIN = WIDTH - LO;   // operand bits still pending

    logic [RIN-1:0] a_in;
    logic [RIN-1:0] b_in;
    logic           c_in;
    logic           v_in;
    logic [SW:0]    slice_c;
    logic [HI-1:0]  res_d;
    logic [HI-1:0]  res_q;
    logic           c_d;
    logic           c_q;
    logic           v_d;
    logic           v_q;

    if (k == 0) begin : g_src
      // b is conditionally inverted at capture; carry-in of sub makes A+~B+1.
      assign a_in = io.a;
      assign b_in = io.b ^ {WIDTH{io.sub}};
      assign c_in = io.sub;
      assign v_in = io.in_valid;
      always_comb res_d = slice_c[SW-1:0];
    end else begin : g_src
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      always_comb res_d = {slice_c[SW-1:0], g_stage[k-1].res_q};
    end

    // One slice of the ripple chain, using the low pending operand bits.
    always_comb begin
      slice_c = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + SWP'(c_in);
      c_d     = slice_c[SW];
      v_d     = v_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv_c) begin
        v_q   <= v_d;
        c_q   <= c_d;
        res_q <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int unsigned ROUT = RIN - SW;
      logic [ROUT-1:0] a_d;
      logic [ROUT-1:0] a_q;
      logic [ROUT-1:0] b_d;
      logic [ROUT-1:0] b_q;

      // Forward only the operand bits later stages still need.
      always_comb begin
        a_d = a_in[RIN-1:SW];
        b_d = b_in[RIN-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv_c) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^sum at that bit.
      always_comb ovf_d = a_in[RIN-1] ^ b_in[RIN-1] ^ slice_c[SW-1] ^ slice_c[SW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_c) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign io.out_valid = g_stage[STAGES-1].v_q;
  assign io.sum       = g_stage[STAGES-1].res_q;
  assign io.cout      = g_stage[STAGES-1].c_q;
  assign io.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
